// File: rtl/fiat_25519_pkg.sv
// Shared constants, types and state encoding for the curve25519
// carry-chain datapath.
package fiat_25519_pkg;

   localparam int NLIMB       = 10;
   localparam int LIMB_W_EVEN = 26;
   localparam int LIMB_W_ODD  = 25;
   localparam int WRAP_CONST  = 19;
   localparam int ACC_W       = 64;
   localparam int OUT_W       = 32;
   localparam int IDX_W       = 4;
   localparam int CARRY_W     = ACC_W + 1 - LIMB_W_ODD;
   localparam int L0_W        = CARRY_W + 6;

   typedef enum logic [2:0] {
      LOAD,
      CARRY,
      WRAP,
      FIX,
      EMIT
   } state_t;

   typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/fiat_25519_mul19.sv
// Combinational multiply-by-19 for the wrap-around step,
// built as (c<<4)+(c<<1)+c.
module fiat_25519_mul19
   import fiat_25519_pkg::*;
(
   input  logic [CARRY_W-1:0] c,
   output logic [L0_W-1:0]    p
);

   logic [L0_W-1:0] ce;

   assign ce = L0_W'(c);
   assign p  = (ce << 4) + (ce << 1) + ce;

endmodule

// File: rtl/fiat_25519_carry_chain.sv
// Serial radix-2^25.5 carry chain: load ten accumulators, propagate
// carries, fold the top carry back times 19, then stream ten limbs.
module fiat_25519_carry_chain
   import fiat_25519_pkg::*;
(
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ACC_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last
);

   state_t state, state_n;
   idx_t   idx, j;

   logic [CARRY_W-1:0] c, c_n;
   logic [ACC_W-1:0]   acc  [NLIMB];
   logic [OUT_W-1:0]   limb [1:NLIMB-1];
   logic [L0_W-1:0]    l0;
   logic [L0_W-1:0]    p19;

   logic [ACC_W:0]         t;
   logic [LIMB_W_EVEN-1:0] lo;
   logic                   even;
   logic                   take;
   logic                   fire;
   logic                   last_idx;
   logic                   last_j;

   assign take     = in_valid & in_ready;
   assign fire     = out_valid & out_ready;
   assign last_idx = (idx == idx_t'(NLIMB - 1));
   assign last_j   = (j == idx_t'(NLIMB - 1));
   assign even     = ~idx[0];

   // t is one bit wider than the accumulator so acc+c never loses a carry
   assign t  = {1'b0, acc[idx]} + (ACC_W + 1)'(c);
   assign lo = even ? t[LIMB_W_EVEN-1:0]
                    : {1'b0, t[LIMB_W_ODD-1:0]};
   assign c_n = even ? {1'b0, t[ACC_W:LIMB_W_EVEN]}
                     : t[ACC_W:LIMB_W_ODD];

   fiat_25519_mul19 u_mul19 (
      .c (c),
      .p (p19)
   );

   always_comb begin
      state_n = state;
      unique case (state)
         LOAD:    if (take && last_idx) state_n = CARRY;
         CARRY:   if (last_idx) state_n = WRAP;
         WRAP:    state_n = FIX;
         FIX:     state_n = EMIT;
         EMIT:    if (fire && last_j) state_n = LOAD;
         default: state_n = LOAD;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state     <= LOAD;
         idx       <= '0;
         j         <= '0;
         c         <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         state    <= state_n;
         in_ready <= (state_n == LOAD);
         case (state)
            LOAD: begin
               c <= '0;
               if (take) idx <= last_idx ? '0 : idx + 1'b1;
            end
            CARRY: begin
               c   <= c_n;
               idx <= last_idx ? '0 : idx + 1'b1;
            end
            FIX: begin
               out_valid <= 1'b1;
               out_data  <= OUT_W'(l0[LIMB_W_EVEN-1:0]);
               out_last  <= 1'b0;
               j         <= '0;
            end
            EMIT: begin
               if (fire) begin
                  if (last_j) begin
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     out_last  <= 1'b0;
                     j         <= '0;
                  end else begin
                     j        <= j + 1'b1;
                     out_data <= limb[j + 1'b1];
                     out_last <= (j + 1'b1 == idx_t'(NLIMB - 1));
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // limb 0 lives in a wider register so it can absorb 19*c before FIX
   always_ff @(posedge ap_clk) begin
      case (state)
         LOAD: begin
            if (take) acc[idx] <= in_data;
         end
         CARRY: begin
            if (idx == '0) l0 <= L0_W'(lo);
            else           limb[idx] <= OUT_W'(lo);
         end
         WRAP: begin
            l0 <= l0 + p19;
         end
         FIX: begin
            l0      <= L0_W'(l0[LIMB_W_EVEN-1:0]);
            limb[1] <= limb[1] + OUT_W'(l0[L0_W-1:LIMB_W_EVEN]);
         end
         default: ;
      endcase
   end

endmodule
